// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the parametrised MIPS register file.
package regfile_pkg;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned REG_SP   = 29;
  localparam int unsigned REG_FP   = 30;
  localparam int unsigned REG_RA   = 31;

  localparam logic [31:0] SP_INIT_DEF = 32'h0000_00CC;

  typedef enum logic {
    HILO_IDLE = 1'b0,
    HILO_BUSY = 1'b1
  } hilo_state_t;

  // Address width for a register file of n entries.
  function automatic int unsigned regfile_aw(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode/writeback facing bus of the register file.
interface regfile_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2
);
  localparam int unsigned AW = regfile_aw(NUM_REGS);

  logic [NUM_RD*AW-1:0]     raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     we;
  logic [AW-1:0]            waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     resv_en;
  logic [AW-1:0]            resv_addr;
  logic                     hi_we;
  logic                     lo_we;
  logic [DATA_W-1:0]        hi_wdata;
  logic [DATA_W-1:0]        lo_wdata;
  logic                     hilo_resv;
  logic [DATA_W-1:0]        hi_rdata;
  logic [DATA_W-1:0]        lo_rdata;
  logic                     hilo_busy;
  logic [DATA_W-1:0]        dbg_data;

  modport master (
    output raddr, we, waddr, wdata, resv_en, resv_addr,
           hi_we, lo_we, hi_wdata, lo_wdata, hilo_resv,
    input  rdata, rbusy, hi_rdata, lo_rdata, hilo_busy, dbg_data
  );

  modport slave (
    input  raddr, we, waddr, wdata, resv_en, resv_addr,
           hi_we, lo_we, hi_wdata, lo_wdata, hilo_resv,
    output rdata, rbusy, hi_rdata, lo_rdata, hilo_busy, dbg_data
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits and HI/LO busy reservation FSM.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned AW      = regfile_aw(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic                resv_en_i,
  input  logic [AW-1:0]       resv_addr_i,
  input  logic                hilo_resv_i,
  input  logic                hilo_wr_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                hilo_busy_o
);

  localparam logic [0:0] ST_IDLE = 1'(HILO_IDLE);
  localparam logic [0:0] ST_BUSY = 1'(HILO_BUSY);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [0:0]          state_q, state_d;

  // Writeback clears, reservation sets; a new producer wins on the same index.
  always_comb begin
    pending_d = pending_q;
    if (we_i) begin
      pending_d[waddr_i] = 1'b0;
    end
    if (resv_en_i) begin
      pending_d[resv_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // HI/LO next state: a fresh mul/div issue overrides a completing write.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hilo_resv_i) state_d = ST_BUSY;
      ST_BUSY: if (!hilo_resv_i && hilo_wr_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Scoreboard state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      state_q   <= ST_IDLE;
    end else begin
      pending_q <= pending_d;
      state_q   <= state_d;
    end
  end

  assign pending_o   = pending_q;
  assign hilo_busy_o = (state_q == ST_BUSY);

endmodule

// File: rtl/regfile_mc.sv
// Parametrised MIPS GPR file with HI/LO, write bypass and pending scoreboard.
module regfile_mc
  import regfile_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NUM_REGS = 32,
  parameter int unsigned       NUM_RD   = 2,
  parameter bit                BYPASS   = 1'b1,
  parameter int unsigned       SP_IDX   = REG_SP,
  parameter int unsigned       FP_IDX   = REG_FP,
  parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEF),
  parameter int unsigned       DBG_IDX  = 3
) (
  input logic      clk,
  input logic      rst,
  regfile_if.slave bus
);

  localparam int unsigned AW = regfile_aw(NUM_REGS);

  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic [DATA_W-1:0]        hi_q, hi_d, lo_q, lo_d;
  logic [NUM_REGS-1:0]      pending;
  logic [NUM_RD*DATA_W-1:0] rdata_c;
  logic [NUM_RD-1:0]        rbusy_c;
  logic [AW-1:0]            ra;

  regfile_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk         (clk),
    .rst         (rst),
    .we_i        (bus.we),
    .waddr_i     (bus.waddr),
    .resv_en_i   (bus.resv_en),
    .resv_addr_i (bus.resv_addr),
    .hilo_resv_i (bus.hilo_resv),
    .hilo_wr_i   (bus.hi_we | bus.lo_we),
    .pending_o   (pending),
    .hilo_busy_o (bus.hilo_busy)
  );

  // Next storage contents; $0 is never written.
  always_comb begin
    regs_d = regs_q;
    if (bus.we && (bus.waddr != '0)) begin
      regs_d[bus.waddr] = bus.wdata;
    end
    hi_d = bus.hi_we ? bus.hi_wdata : hi_q;
    lo_d = bus.lo_we ? bus.lo_wdata : lo_q;
  end

  // Storage registers; SP/FP come out of reset at SP_INIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= ((i == SP_IDX) || (i == FP_IDX)) ? SP_INIT : '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      regs_q <= regs_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    ra      = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = bus.raddr[k*AW +: AW];
      if (ra == '0) begin
        rdata_c[k*DATA_W +: DATA_W] = '0;
        rbusy_c[k]                  = 1'b0;
      end else if (BYPASS && bus.we && (bus.waddr == ra)) begin
        rdata_c[k*DATA_W +: DATA_W] = bus.wdata;
        rbusy_c[k]                  = 1'b0;
      end else begin
        rdata_c[k*DATA_W +: DATA_W] = regs_q[ra];
        rbusy_c[k]                  = pending[ra];
      end
    end
  end

  assign bus.rdata    = rdata_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.hi_rdata = hi_q;
  assign bus.lo_rdata = lo_q;
  assign bus.dbg_data = regs_q[AW'(DBG_IDX)];

endmodule

// File: tb/tb_regfile_mc.sv
// Directed + random bench for regfile_mc, bypass and non-bypass builds side by side.
module tb_regfile_mc;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 32;
  localparam int unsigned ND = 2;
  localparam int unsigned AW = 5;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  // reference model state
  logic [31:0] mregs [32];
  bit          mpend [32];
  logic [31:0] mhi, mlo;
  bit          mbusy;

  regfile_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND)) bus  ();
  regfile_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND)) bus0 ();

  regfile_mc #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  regfile_mc #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(ND), .BYPASS(1'b0)) dut_nb (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  assign bus0.raddr     = bus.raddr;
  assign bus0.we        = bus.we;
  assign bus0.waddr     = bus.waddr;
  assign bus0.wdata     = bus.wdata;
  assign bus0.resv_en   = bus.resv_en;
  assign bus0.resv_addr = bus.resv_addr;
  assign bus0.hi_we     = bus.hi_we;
  assign bus0.lo_we     = bus.lo_we;
  assign bus0.hi_wdata  = bus.hi_wdata;
  assign bus0.lo_wdata  = bus.lo_wdata;
  assign bus0.hilo_resv = bus.hilo_resv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] port_addr(input int k);
    logic [9:0] ra;
    ra = bus.raddr;
    return ra[k*5 +: 5];
  endfunction

  function automatic logic [31:0] exp_rdata(input int k, input bit byp);
    logic [4:0] a;
    a = port_addr(k);
    if (a == 5'd0) return 32'h0;
    if (byp && bus.we && bus.waddr == a) return bus.wdata;
    return mregs[a];
  endfunction

  function automatic logic [31:0] exp_rbusy(input int k, input bit byp);
    logic [4:0] a;
    a = port_addr(k);
    if (a == 5'd0) return 32'h0;
    if (byp && bus.we && bus.waddr == a) return 32'h0;
    return {31'h0, mpend[a]};
  endfunction

  // Apply the architectural rules for one clock edge.
  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = 32'h0;
        mpend[i] = 1'b0;
      end
      mregs[29] = 32'h0000_00CC;
      mregs[30] = 32'h0000_00CC;
      mhi = 32'h0;
      mlo = 32'h0;
      mbusy = 1'b0;
    end else begin
      if (bus.we && bus.waddr != 5'd0) mregs[bus.waddr] = bus.wdata;
      if (bus.we) mpend[bus.waddr] = 1'b0;
      if (bus.resv_en && bus.resv_addr != 5'd0) mpend[bus.resv_addr] = 1'b1;
      if (bus.hi_we) mhi = bus.hi_wdata;
      if (bus.lo_we) mlo = bus.lo_wdata;
      if (bus.hilo_resv) mbusy = 1'b1;
      else if (bus.hi_we || bus.lo_we) mbusy = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rdata%0d", k),    bus.rdata[k*32 +: 32],  exp_rdata(k, 1'b1));
      chk($sformatf("rbusy%0d", k),    {31'h0, bus.rbusy[k]},  exp_rbusy(k, 1'b1));
      chk($sformatf("nb_rdata%0d", k), bus0.rdata[k*32 +: 32], exp_rdata(k, 1'b0));
      chk($sformatf("nb_rbusy%0d", k), {31'h0, bus0.rbusy[k]}, exp_rbusy(k, 1'b0));
    end
    chk("hi",        bus.hi_rdata,            mhi);
    chk("lo",        bus.lo_rdata,            mlo);
    chk("hilo_busy", {31'h0, bus.hilo_busy},  {31'h0, mbusy});
    chk("dbg",       bus.dbg_data,            mregs[3]);
    chk("nb_dbg",    bus0.dbg_data,           mregs[3]);
  endtask

  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.resv_en = 1'b0; bus.resv_addr = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.hi_wdata = '0; bus.lo_wdata = '0;
    bus.hilo_resv = 1'b0;
  endtask

  task automatic rd(input logic [4:0] p0, input logic [4:0] p1);
    bus.raddr = {p1, p0};
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle();
    rd(5'd29, 5'd30);
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    step();
    rst = 1'b0;

    // reset values
    #1;
    chk("sp_reset", bus.rdata[31:0],  32'h0000_00CC);
    chk("fp_reset", bus.rdata[63:32], 32'h0000_00CC);
    chk("rbusy_reset", {30'h0, bus.rbusy}, 32'h0);
    rd(5'd5, 5'd30);
    #1;
    chk("r5_reset", bus.rdata[31:0], 32'h0);
    chk("hi_reset", bus.hi_rdata, 32'h0);
    chk("lo_reset", bus.lo_rdata, 32'h0);
    chk("busy_reset", {31'h0, bus.hilo_busy}, 32'h0);
    chk("dbg_reset", bus.dbg_data, 32'h0);
    step();

    // writes and reservations of $0 are dropped
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hDEAD_BEEF; rd(5'd0, 5'd0);
    #1;
    chk("r0_bypass", bus.rdata[31:0], 32'h0);
    step();
    idle();
    bus.resv_en = 1'b1; bus.resv_addr = 5'd0;
    #1;
    chk("r0_after_wr", bus.rdata[31:0], 32'h0);
    step();
    idle();
    #1;
    chk("r0_rbusy", {31'h0, bus.rbusy[0]}, 32'h0);
    step();

    // bypass vs. non-bypass
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'h1234_5678; rd(5'd0, 5'd7);
    #1;
    chk("bypass_on",  bus.rdata[63:32],  32'h1234_5678);
    chk("bypass_off", bus0.rdata[63:32], 32'h0);
    step();
    idle();
    #1;
    chk("nb_next", bus0.rdata[63:32], 32'h1234_5678);
    step();

    // pending scoreboard
    bus.resv_en = 1'b1; bus.resv_addr = 5'd9; rd(5'd9, 5'd7);
    #1;
    chk("pend_pre", {31'h0, bus.rbusy[0]}, 32'h0);
    step();
    idle();
    #1;
    chk("pend_set", {31'h0, bus.rbusy[0]}, 32'h1);
    step();
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h55; bus.resv_en = 1'b1; bus.resv_addr = 5'd9;
    step();
    idle();
    #1;
    chk("pend_set_wins", {31'h0, bus.rbusy[0]}, 32'h1);
    step();
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h66;
    step();
    idle();
    #1;
    chk("pend_clr", {31'h0, bus.rbusy[0]}, 32'h0);
    chk("pend_clr_nb", {31'h0, bus0.rbusy[0]}, 32'h0);
    step();

    // HI/LO reservation
    bus.hilo_resv = 1'b1;
    step();
    idle();
    #1;
    chk("hilo_busy_set", {31'h0, bus.hilo_busy}, 32'h1);
    bus.hi_we = 1'b1; bus.hi_wdata = 32'h0000_0001;
    bus.lo_we = 1'b1; bus.lo_wdata = 32'hFFFF_FFFE;
    #1;
    chk("hilo_no_bypass", bus.hi_rdata, 32'h0);
    step();
    idle();
    #1;
    chk("hilo_busy_clr", {31'h0, bus.hilo_busy}, 32'h0);
    chk("hi_val", bus.hi_rdata, 32'h0000_0001);
    chk("lo_val", bus.lo_rdata, 32'hFFFF_FFFE);
    step();

    // reset in the middle of outstanding work
    bus.resv_en = 1'b1; bus.resv_addr = 5'd12; bus.hilo_resv = 1'b1;
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 32'd42; rd(5'd12, 5'd3);
    step();
    idle();
    #1;
    chk("mid_dbg", bus.dbg_data, 32'd42);
    chk("mid_busy", {31'h0, bus.hilo_busy}, 32'h1);
    chk("mid_pend", {31'h0, bus.rbusy[0]}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_rbusy", {30'h0, bus.rbusy}, 32'h0);
    chk("rst_busy", {31'h0, bus.hilo_busy}, 32'h0);
    chk("rst_dbg", bus.dbg_data, 32'h0);
    step();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] p0, p1;
      rst = ($urandom_range(0, 63) == 0);
      bus.we = $urandom_range(0, 1) == 1;
      bus.waddr = 5'($urandom_range(0, 31));
      bus.wdata = $urandom;
      bus.resv_en = $urandom_range(0, 2) == 0;
      bus.resv_addr = ($urandom_range(0, 3) == 0) ? bus.waddr : 5'($urandom_range(0, 31));
      bus.hi_we = $urandom_range(0, 3) == 0;
      bus.lo_we = $urandom_range(0, 3) == 0;
      bus.hi_wdata = $urandom;
      bus.lo_wdata = $urandom;
      bus.hilo_resv = $urandom_range(0, 5) == 0;
      p0 = 5'($urandom_range(0, 31));
      p1 = ($urandom_range(0, 1) == 1) ? bus.waddr : 5'($urandom_range(0, 31));
      rd(p0, p1);
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mc.md
Name: regfile_mc

Overview:
- Parametrised next-generation MIPS register file, generalised in data width, register count and number of read ports.
- Adds optional write-to-read bypass, a per-register pending scoreboard for multi-cycle producers (loads, long-latency ops) and a HI/LO busy reservation for the multiply/divide unit.
- Sits between decode (reads, reserve requests) and writeback (writes, release of pending state).

Parameters:
- DATA_W, 32, register/HI/LO data width.
- NUM_REGS, 32, architectural GPR count incl. $0; power of two, >=4.
- NUM_RD, 2, independent combinational read ports, 1..4.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports.
- SP_IDX, 29, index reset to SP_INIT.
- FP_IDX, 30, index reset to SP_INIT.
- SP_INIT, 32'h0000_00CC, reset value of SP_IDX/FP_IDX.
- DBG_IDX, 3, register driven on dbg_data.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- raddr  in  NUM_RD*AW  packed read addresses; port k = [k*AW +: AW], AW = $clog2(NUM_REGS).
- rdata  out  NUM_RD*DATA_W  packed read data, same packing.
- rbusy  out  NUM_RD  port k's register has a pending producer.
- we  in  1  GPR write enable.
- waddr  in  AW  GPR write address.
- wdata  in  DATA_W  GPR write data; a write also releases that register's pending bit.
- resv_en  in  1  mark resv_addr pending.
- resv_addr  in  AW  register being reserved.
- hi_we  in  1  HI write enable.
- lo_we  in  1  LO write enable.
- hi_wdata  in  DATA_W  HI write data.
- lo_wdata  in  DATA_W  LO write data.
- hilo_resv  in  1  mul/div issued; HI/LO become busy.
- hi_rdata  out  DATA_W  HI value.
- lo_rdata  out  DATA_W  LO value.
- hilo_busy  out  1  HI/LO reservation outstanding.
- dbg_data  out  DATA_W  contents of DBG_IDX.

Behaviour:
- Reset (rst high at clk edge): all GPRs 0, except SP_IDX and FP_IDX = SP_INIT.
  - HI, LO, all pending bits and hilo_busy cleared.
  - All write/reserve inputs ignored that cycle.
- Reset outputs, given raddr != SP_IDX/FP_IDX: rdata 0, rbusy 0, hi_rdata/lo_rdata 0, hilo_busy 0, dbg_data 0 (DBG_IDX default 3).
- Reads: combinational, zero latency.
  - Address 0 always returns 0 with rbusy 0.
  - Otherwise returns the stored value.
- Bypass (BYPASS=1): if we && waddr==raddr[k] && waddr!=0, rdata[k]=wdata and rbusy[k]=0 in the same cycle.
  - BYPASS=0: the new value is visible the cycle after the edge; rbusy stays at its stored value until then.
- GPR write: stored on the edge when we && waddr!=0. Writes to $0 are dropped.
- Pending bit per register (bit 0 tied 0):
  - Set on resv_en && resv_addr!=0.
  - Cleared on we && waddr==same index.
  - Same index, same cycle: set wins (new producer supersedes).
  - Reserving an already-pending register keeps it pending; no counting.
  - rbusy[k] = pending[raddr[k]], with the bypass override above.
- HI/LO writes: independent enables; both may fire in one cycle. No bypass on HI/LO outputs.
- HI/LO busy FSM, 2 states:
  - IDLE -> BUSY on hilo_resv.
  - BUSY -> IDLE on the edge where hi_we or lo_we is high.
  - hilo_resv and a HI/LO write in the same cycle -> BUSY (new op wins).
  - hilo_resv while BUSY -> stays BUSY.
  - hilo_busy = (state==BUSY), registered.
- Reset mid-operation: all pending and busy state lost; producers are flushed by the pipeline.
- dbg_data: raw storage read of DBG_IDX, no bypass.

Decomposition:
- Shared package regfile_pkg:
  - MIPS register index constants (REG_ZERO, REG_SP=29, REG_FP=30, REG_RA=31).
  - SP_INIT default.
  - hilo_state_t enum {HILO_IDLE, HILO_BUSY}.
  - AW function wrapper.
- One natural sub-module: regfile_scoreboard, holding the pending bit vector plus the HI/LO busy FSM with set/clear priority.
- Storage and read muxes stay in regfile_mc.

Test Plan:
- Reset, then read ports 29, 30, 5 -> 32'h0000_00CC, 32'h0000_00CC, 0; HI=LO=0; rbusy=0; hilo_busy=0.
- we=1, waddr=0, wdata=32'hDEAD_BEEF -> next cycle read of 0 returns 0; resv_en on addr 0 -> rbusy 0.
- BYPASS=1: we=1, waddr=7, wdata=32'h1234_5678 with raddr port1=7 in the same cycle -> rdata[1]=32'h1234_5678 combinationally.
  - BYPASS=0 -> old value 0 that cycle, 32'h1234_5678 the next.
- resv_en addr 9 -> rbusy on port reading 9 goes 1 the next cycle.
  - Later, same-cycle we waddr 9 and resv_en 9 -> rbusy stays 1.
  - Then we waddr 9 alone -> rbusy 0.
- hilo_resv pulse -> hilo_busy=1 the next cycle.
  - hi_we=1, hi_wdata=32'h0000_0001, lo_we=1, lo_wdata=32'hFFFF_FFFE -> hilo_busy 0, HI=1, LO=32'hFFFF_FFFE.
- Mid-operation reset: reserve reg 12, hilo_resv, write reg 3=42, then rst -> all rbusy 0, hilo_busy 0, dbg_data 0.
